// File: rtl/carrier_offset_rotator.sv
// rtl/carrier_offset_rotator.sv - carrier-offset de-rotation of a 2-bit I/Q stream
//
// Purpose: rotates each accepted I/Q sample by theta[n] = n*PHASE_INC, where n
// counts accepted samples since reset. The phase accumulator drives a 64-point
// quarter-wave sine table (12-bit signed coefficients). There is one register stage.
//
// Ports:
//   clk   in   1   system clock, rising edge
//   rst   in   1   asynchronous active-high reset (clears phase and outputs)
//   en    in   1   sample valid; advances phase and updates outputs
//   I     in   2   in-phase sample, two's complement (-2..+1)
//   Q     in   2   quadrature sample, two's complement (-2..+1)
//   I_ro  out  14  I*cos + Q*sin, two's complement
//   Q_ro  out  14  Q*cos - I*sin, two's complement

module carrier_offset_rotator #(
  parameter int          PHASE_W   = 16,
  parameter int unsigned PHASE_INC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  I,
  input  logic [1:0]  Q,
  output logic [13:0] I_ro,
  output logic [13:0] Q_ro
);

  localparam logic [PHASE_W-1:0] INC = PHASE_W'(PHASE_INC);

  logic [PHASE_W-1:0] phase;
  logic [5:0]         k;
  logic [1:0]         quad;
  logic [3:0]         r;
  logic [11:0]        s_r;
  logic [11:0]        s_c;
  logic signed [11:0] sin_c;
  logic signed [11:0] cos_c;
  logic signed [13:0] i_ext;
  logic signed [13:0] q_ext;
  logic signed [13:0] sin_ext;
  logic signed [13:0] cos_ext;
  logic signed [13:0] i_next;
  logic signed [13:0] q_next;

  // Quarter-wave table: round(2047*sin(2*pi*j/64)), j = 0..16.
  function automatic logic [11:0] s_lut(input logic [4:0] j);
    case (j)
      5'd0:    s_lut = 12'd0;
      5'd1:    s_lut = 12'd201;
      5'd2:    s_lut = 12'd399;
      5'd3:    s_lut = 12'd594;
      5'd4:    s_lut = 12'd783;
      5'd5:    s_lut = 12'd965;
      5'd6:    s_lut = 12'd1137;
      5'd7:    s_lut = 12'd1299;
      5'd8:    s_lut = 12'd1447;
      5'd9:    s_lut = 12'd1582;
      5'd10:   s_lut = 12'd1702;
      5'd11:   s_lut = 12'd1805;
      5'd12:   s_lut = 12'd1891;
      5'd13:   s_lut = 12'd1959;
      5'd14:   s_lut = 12'd2008;
      5'd15:   s_lut = 12'd2037;
      default: s_lut = 12'd2047;
    endcase
  endfunction

  assign k    = phase[PHASE_W-1 -: 6];
  assign quad = k[5:4];
  assign r    = k[3:0];

  // s_r is sin of the in-quadrant offset; s_c is its complement (cos).
  // Because r <= 15, index 16-r never goes below 1.
  assign s_r = s_lut({1'b0, r});
  assign s_c = s_lut(5'd16 - {1'b0, r});

  always_comb begin
    sin_c = 12'sd0;
    cos_c = 12'sd0;
    case (quad)
      2'd0: begin
        sin_c = $signed(s_r);
        cos_c = $signed(s_c);
      end
      2'd1: begin
        sin_c = $signed(s_c);
        cos_c = -$signed(s_r);
      end
      2'd2: begin
        sin_c = -$signed(s_r);
        cos_c = -$signed(s_c);
      end
      default: begin
        sin_c = -$signed(s_c);
        cos_c = $signed(s_r);
      end
    endcase
  end

  // Every operand is widened to the 14-bit result width. Each product is at
  // most 2*2047 and each sum at most 8188 in magnitude, so no bits are lost.
  assign i_ext   = {{12{I[1]}}, I};
  assign q_ext   = {{12{Q[1]}}, Q};
  assign sin_ext = {{2{sin_c[11]}}, sin_c};
  assign cos_ext = {{2{cos_c[11]}}, cos_c};

  assign i_next = i_ext * cos_ext + q_ext * sin_ext;
  assign q_next = q_ext * cos_ext - i_ext * sin_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      I_ro  <= '0;
      Q_ro  <= '0;
    end else if (en) begin
      phase <= phase + INC;
      I_ro  <= i_next;
      Q_ro  <= q_next;
    end
  end

endmodule

// File: tb/tb_carrier_offset_rotator.sv
// tb/tb_carrier_offset_rotator.sv - randomized self-checking bench for carrier_offset_rotator

module tb_carrier_offset_rotator;

  localparam int          PHASE_W   = 16;
  localparam int unsigned PHASE_INC = 64;
  localparam real         PI        = 3.14159265358979323846;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  I;
  logic [1:0]  Q;
  logic [13:0] I_ro;
  logic [13:0] Q_ro;

  int checks;
  int errors;

  int n_acc;
  int exp_i;
  int exp_q;

  carrier_offset_rotator #(
    .PHASE_W  (PHASE_W),
    .PHASE_INC(PHASE_INC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .I   (I),
    .Q   (Q),
    .I_ro(I_ro),
    .Q_ro(Q_ro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(-x + 0.5);
  endfunction

  // Reference rotation computed directly from the trig definition.
  function automatic void model(input int n, input int iv, input int qv,
                                output int ei, output int eq);
    longint ph;
    int     kk;
    real    th;
    int     s;
    int     c;
    ph = (longint'(n) * longint'(PHASE_INC)) % (longint'(1) << PHASE_W);
    kk = int'(ph >> (PHASE_W - 6));
    th = 2.0 * PI * real'(kk) / 64.0;
    s  = rnd(2047.0 * $sin(th));
    c  = rnd(2047.0 * $cos(th));
    ei = iv * c + qv * s;
    eq = qv * c - iv * s;
  endfunction

  function automatic int to_int14(input logic [13:0] v);
    return int'($signed(v));
  endfunction

  // Apply one enabled sample and advance the reference model.
  task automatic drive_sample(input int iv, input int qv);
    logic [31:0] bi;
    logic [31:0] bq;
    bi = iv;
    bq = qv;
    @(negedge clk);
    en = 1'b1;
    I  = bi[1:0];
    Q  = bq[1:0];
    model(n_acc, iv, qv, exp_i, exp_q);
    n_acc++;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    I   = 2'b00;
    Q   = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (I_ro !== 14'd0 || Q_ro !== 14'd0) begin
      errors++;
      $display("FAIL reset_hold I_ro=%0d Q_ro=%0d expected 0 0", to_int14(I_ro), to_int14(Q_ro));
    end
    @(negedge clk);
    rst = 1'b0;
    n_acc = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (I_ro !== 14'd0 || Q_ro !== 14'd0) begin
      errors++;
      $display("FAIL reset_release I_ro=%0d Q_ro=%0d expected 0 0", to_int14(I_ro), to_int14(Q_ro));
    end
  endtask

  task automatic test_first_sample();
    drive_sample(1, -1);
    checks++;
    if (to_int14(I_ro) !== 2047 || to_int14(Q_ro) !== -2047) begin
      errors++;
      $display("FAIL first_sample I_ro=%0d Q_ro=%0d expected 2047 -2047", to_int14(I_ro), to_int14(Q_ro));
    end
  endtask

  // Runs up to sample index `target` with random data, checking each against the model.
  task automatic run_to(input int target, input string tag);
    int iv;
    int qv;
    int bad;
    bad = 0;
    while (n_acc < target) begin
      iv = int'($urandom_range(3)) - 2;
      qv = int'($urandom_range(3)) - 2;
      drive_sample(iv, qv);
      checks++;
      if (to_int14(I_ro) !== exp_i || to_int14(Q_ro) !== exp_q) begin
        errors++;
        if (bad < 5)
          $display("FAIL %s n=%0d I_ro=%0d Q_ro=%0d expected %0d %0d",
                   tag, n_acc - 1, to_int14(I_ro), to_int14(Q_ro), exp_i, exp_q);
        bad++;
      end
    end
  endtask

  task automatic test_odd_extremes();
    run_to(16, "fill_k1");
    drive_sample(-2, -2);
    checks++;
    if (to_int14(I_ro) !== -4476 || to_int14(Q_ro) !== -3672) begin
      errors++;
      $display("FAIL odd_extremes I_ro=%0d Q_ro=%0d expected -4476 -3672", to_int14(I_ro), to_int14(Q_ro));
    end
  endtask

  task automatic test_quadrature();
    run_to(256, "fill_k16");
    drive_sample(1, 0);
    checks++;
    if (to_int14(I_ro) !== 0 || to_int14(Q_ro) !== -2047) begin
      errors++;
      $display("FAIL quadrature I_ro=%0d Q_ro=%0d expected 0 -2047", to_int14(I_ro), to_int14(Q_ro));
    end
  endtask

  task automatic test_half_turn();
    run_to(512, "fill_k32");
    drive_sample(1, 1);
    checks++;
    if (to_int14(I_ro) !== -2047 || to_int14(Q_ro) !== -2047) begin
      errors++;
      $display("FAIL half_turn I_ro=%0d Q_ro=%0d expected -2047 -2047", to_int14(I_ro), to_int14(Q_ro));
    end
  endtask

  // Hold just before a k boundary so a stray phase advance would change the result.
  task automatic test_hold();
    run_to(527, "fill_hold");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      en = 1'b0;
      I  = 2'($urandom_range(3));
      Q  = 2'($urandom_range(3));
      @(posedge clk);
      #1;
      checks++;
      if (to_int14(I_ro) !== exp_i || to_int14(Q_ro) !== exp_q) begin
        errors++;
        $display("FAIL hold_cycle%0d I_ro=%0d Q_ro=%0d expected %0d %0d",
                 c, to_int14(I_ro), to_int14(Q_ro), exp_i, exp_q);
      end
    end
    drive_sample(-2, 1);
    checks++;
    if (to_int14(I_ro) !== exp_i || to_int14(Q_ro) !== exp_q) begin
      errors++;
      $display("FAIL hold_resume I_ro=%0d Q_ro=%0d expected %0d %0d",
               to_int14(I_ro), to_int14(Q_ro), exp_i, exp_q);
    end
  endtask

  task automatic test_wrap();
    run_to(1024, "fill_wrap");
    drive_sample(1, -1);
    checks++;
    if (to_int14(I_ro) !== 2047 || to_int14(Q_ro) !== -2047) begin
      errors++;
      $display("FAIL wrap_1024 I_ro=%0d Q_ro=%0d expected 2047 -2047", to_int14(I_ro), to_int14(Q_ro));
    end
  endtask

  task automatic test_midstream_reset();
    run_to(1100, "fill_rst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (I_ro !== 14'd0 || Q_ro !== 14'd0) begin
      errors++;
      $display("FAIL async_reset I_ro=%0d Q_ro=%0d expected 0 0", to_int14(I_ro), to_int14(Q_ro));
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    rst   = 1'b0;
    n_acc = 0;
    drive_sample(1, 1);
    checks++;
    if (to_int14(I_ro) !== 2047 || to_int14(Q_ro) !== 2047) begin
      errors++;
      $display("FAIL reset_theta0 I_ro=%0d Q_ro=%0d expected 2047 2047", to_int14(I_ro), to_int14(Q_ro));
    end
  endtask

  // 1024 random samples with random idle gaps, all checked against the model.
  task automatic test_golden();
    int iv;
    int qv;
    int bad;
    bad = 0;
    for (int s = 0; s < 1024; s++) begin
      if ($urandom_range(7) == 0) begin
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
      end
      iv = int'($urandom_range(3)) - 2;
      qv = int'($urandom_range(3)) - 2;
      drive_sample(iv, qv);
      checks++;
      if (to_int14(I_ro) !== exp_i || to_int14(Q_ro) !== exp_q) begin
        errors++;
        if (bad < 10)
          $display("FAIL golden n=%0d I=%0d Q=%0d I_ro=%0d Q_ro=%0d expected %0d %0d",
                   n_acc - 1, iv, qv, to_int14(I_ro), to_int14(Q_ro), exp_i, exp_q);
        bad++;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_acc  = 0;
    exp_i  = 0;
    exp_q  = 0;
    test_reset();
    test_first_sample();
    test_odd_extremes();
    test_quadrature();
    test_half_turn();
    test_hold();
    test_wrap();
    test_midstream_reset();
    test_golden();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
